// File: rtl/transmit_dac_pkg.sv
// Shared definitions for the transmit_dac serial DAC transmitter.
// State encodings, default widths and DAC power-down mode codes.
package transmit_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int TX_DATA_W  = 12;
    localparam int TX_FRAME_W = 16;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

endpackage

// File: rtl/transmit_dac_shifter.sv
// FRAME_W-bit load/shift register presenting the frame MSB-first on a
// registered serial output; the FSM drives load, shift and clear.
module transmit_dac_shifter #(
    parameter int FRAME_W = 16
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic               clear,
    input  logic [FRAME_W-1:0] frame,
    output logic               sout
);

    // Holds only the bits not yet presented; the current bit lives in sout.
    logic [FRAME_W-2:0] rest;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            rest <= '0;
            sout <= 1'b0;
        end else if (load) begin
            rest <= frame[FRAME_W-2:0];
            sout <= frame[FRAME_W-1];
        end else if (shift) begin
            rest <= {rest[FRAME_W-3:0], 1'b0};
            sout <= rest[FRAME_W-2];
        end else if (clear) begin
            rest <= '0;
            sout <= 1'b0;
        end
    end

endmodule

// File: rtl/transmit_dac.sv
// Serial transmitter for a 12-bit SPI-style DAC: frames {00, PD, data}
// MSB-first under an active-low sync. Define TRANSMIT_DAC_DUAL_EN for a second channel.
module transmit_dac
    import transmit_dac_pkg::*;
#(
    parameter int         DATA_W  = TX_DATA_W,
    parameter int         FRAME_W = TX_FRAME_W,
    parameter logic [1:0] PD_MODE = PD_NORMAL
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] din,
`ifdef TRANSMIT_DAC_DUAL_EN
    input  logic [DATA_W-1:0] din2,
    output logic              sdata2,
`endif
    output logic              ready,
    output logic              sync,
    output logic              sdata,
    output logic              tx_done_tick
);

    state_t     state, state_next;
    logic [3:0] cnt;
    logic       load, shift, clear;
    logic       sync_next, tick_next;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            sync         <= 1'b1;
            tx_done_tick <= 1'b0;
            cnt          <= 4'd0;
        end else begin
            state        <= state_next;
            sync         <= sync_next;
            tx_done_tick <= tick_next;
            if (load)
                cnt <= 4'd0;
            else if (state == ST_SHIFT)
                cnt <= cnt + 4'd1;
        end
    end

    // GAP behaves like IDLE for acceptance, which gives the 17-cycle back-to-back period.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        clear      = 1'b0;
        case (state)
            ST_IDLE, ST_GAP: begin
                if (tx_start) begin
                    state_next = ST_SHIFT;
                    load       = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt == 4'(FRAME_W - 1)) begin
                    state_next = ST_GAP;
                    clear      = 1'b1;
                end else begin
                    shift = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        sync_next = (state_next != ST_SHIFT);
        tick_next = (state_next == ST_GAP);
    end

    assign ready = (state == ST_IDLE) || (state == ST_GAP);

    transmit_dac_shifter #(.FRAME_W(FRAME_W)) u_shift_a (
        .sclk  (sclk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .clear (clear),
        .frame ({2'b00, PD_MODE, din}),
        .sout  (sdata)
    );

`ifdef TRANSMIT_DAC_DUAL_EN
    transmit_dac_shifter #(.FRAME_W(FRAME_W)) u_shift_b (
        .sclk  (sclk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .clear (clear),
        .frame ({2'b00, PD_MODE, din2}),
        .sout  (sdata2)
    );
`endif

endmodule

// File: tb/tb_transmit_dac.sv
// Directed self-checking bench for transmit_dac; inputs change and outputs
// are sampled on the falling edge of sclk.
module tb_transmit_dac;

`ifdef TRANSMIT_DAC_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    // Status vector order: {sync, ready, tx_done_tick, sdata, sdata2}
    localparam logic [4:0] ST_IDLE_V = 5'b11000;
    localparam logic [4:0] ST_GAP_V  = 5'b11100;

    logic        sclk = 1'b0;
    logic        rst;
    logic        tx_start;
    logic [11:0] din;
    logic [11:0] din2;
    logic        ready;
    logic        sync;
    logic        sdata;
    logic        sdata2;
    logic        tx_done_tick;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    transmit_dac dut (
        .sclk         (sclk),
        .rst          (rst),
        .tx_start     (tx_start),
        .din          (din),
`ifdef TRANSMIT_DAC_DUAL_EN
        .din2         (din2),
        .sdata2       (sdata2),
`endif
        .ready        (ready),
        .sync         (sync),
        .sdata        (sdata),
        .tx_done_tick (tx_done_tick)
    );

`ifndef TRANSMIT_DAC_DUAL_EN
    assign sdata2 = 1'b0;
`endif

    function automatic logic [4:0] status();
        return {sync, ready, tx_done_tick, sdata, sdata2};
    endfunction

    task automatic applyStimulus(input logic start_v, input logic [11:0] d_v, input logic [11:0] d2_v);
        tx_start = start_v;
        din      = d_v;
        din2     = d2_v;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Walks nbits of an active frame; pulse_at >= 0 drives a one-cycle stray start at that bit.
    task automatic checkFrame(input string tag, input logic [15:0] f, input logic [15:0] f2,
                              input int nbits, input int pulse_at);
        for (int k = 0; k < nbits; k++) begin
            checkOutput($sformatf("%s_bit%0d", tag, k), status(),
                        {3'b000, f[15-k], DUAL ? f2[15-k] : 1'b0});
            if (pulse_at >= 0) begin
                if (k == pulse_at)
                    applyStimulus(1'b1, 12'h123, 12'h456);
                else
                    tx_start = 1'b0;
            end
            @(negedge sclk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 12'h000, 12'h000);
        repeat (2) @(negedge sclk);
        checkOutput("in_reset", status(), ST_IDLE_V);
        rst = 1'b0;

        repeat (5) begin
            @(negedge sclk);
            checkOutput("idle", status(), ST_IDLE_V);
        end

        // Single frame 0xA5C
        applyStimulus(1'b1, 12'hA5C, 12'h5A3);
        @(negedge sclk);
        tx_start = 1'b0;
        checkFrame("a5c", 16'h0A5C, 16'h05A3, 16, -1);
        checkOutput("a5c_gap", status(), ST_GAP_V);
        repeat (3) begin
            @(negedge sclk);
            checkOutput("a5c_idle", status(), ST_IDLE_V);
        end

        // Back-to-back with tx_start held high
        applyStimulus(1'b1, 12'hFFF, 12'h000);
        @(negedge sclk);
        din  = 12'h001;
        din2 = 12'hFFE;
        checkFrame("b2b1", 16'h0FFF, 16'h0000, 16, -1);
        checkOutput("b2b_gap1", status(), ST_GAP_V);
        @(negedge sclk);
        tx_start = 1'b0;
        checkFrame("b2b2", 16'h0001, 16'h0FFE, 16, -1);
        checkOutput("b2b_gap2", status(), ST_GAP_V);
        @(negedge sclk);
        checkOutput("b2b_idle", status(), ST_IDLE_V);

        // Stray start at bit 5 is ignored
        applyStimulus(1'b1, 12'h3C6, 12'hC39);
        @(negedge sclk);
        tx_start = 1'b0;
        checkFrame("ign", 16'h03C6, 16'h0C39, 16, 5);
        checkOutput("ign_gap", status(), ST_GAP_V);
        repeat (3) begin
            @(negedge sclk);
            checkOutput("ign_idle", status(), ST_IDLE_V);
        end

        // Reset at bit 8, then start in the first cycle after release
        applyStimulus(1'b1, 12'h555, 12'hAAA);
        @(negedge sclk);
        tx_start = 1'b0;
        checkFrame("abort", 16'h0555, 16'h0AAA, 8, -1);
        rst = 1'b1;
        #1;
        checkOutput("rst_async", status(), ST_IDLE_V);
        @(negedge sclk);
        checkOutput("rst_hold", status(), ST_IDLE_V);
        rst = 1'b0;
        applyStimulus(1'b1, 12'h800, 12'h7FF);
        @(negedge sclk);
        tx_start = 1'b0;
        checkFrame("post_rst", 16'h0800, 16'h07FF, 16, -1);
        checkOutput("post_rst_gap", status(), ST_GAP_V);
        @(negedge sclk);
        checkOutput("post_rst_idle", status(), ST_IDLE_V);

        // Two-channel pattern (sdata2 checked when the second channel exists)
        applyStimulus(1'b1, 12'h0F0, 12'hF0F);
        @(negedge sclk);
        tx_start = 1'b0;
        checkFrame("dual", 16'h00F0, 16'h0F0F, 16, -1);
        checkOutput("dual_gap", status(), ST_GAP_V);
        @(negedge sclk);
        checkOutput("dual_idle", status(), ST_IDLE_V);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
